// File: rtl/prv664_pkg.sv
// Shared prv664 definitions: writeback defaults and payload type.
package prv664_pkg;

  localparam int unsigned WB_NPORT  = 4;
  localparam int unsigned WB_XLEN   = 64;
  localparam int unsigned WB_ITAG_W = 8;

  // Result carried from an execution unit to the ROB/regfile
  typedef struct packed {
    logic [WB_XLEN-1:0]   data;
    logic [WB_ITAG_W-1:0] itag;
  } wb_payload_t;

endpackage

// File: rtl/wb_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found_c;

  // Two passes: indices ptr..N-1 first, then the wrapped range 0..ptr-1
  always_comb begin
    gnt     = '0;
    found_c = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_c && req[j] && (j >= 32'(ptr))) begin
        gnt[j]  = 1'b1;
        found_c = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found_c && req[j] && (j < 32'(ptr))) begin
        gnt[j]  = 1'b1;
        found_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arb.sv
// Writeback arbiter: round-robin selection of EU results into a single registered writeback port.
module wb_arb
  import prv664_pkg::*;
#(
  parameter int unsigned NPORT  = WB_NPORT,
  parameter int unsigned XLEN   = WB_XLEN,
  parameter int unsigned ITAG_W = WB_ITAG_W
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      flush_i,
  input  logic [NPORT-1:0]          src_valid_i,
  output logic [NPORT-1:0]          src_ready_o,
  input  logic [NPORT*XLEN-1:0]     src_data_i,
  input  logic [NPORT*ITAG_W-1:0]   src_itag_i,
  output logic                      wb_valid_o,
  input  logic                      wb_ready_i,
  output logic [XLEN-1:0]           wb_data_o,
  output logic [ITAG_W-1:0]         wb_itag_o,
  output logic [$clog2(NPORT)-1:0]  wb_src_o
);

  localparam int unsigned SRC_W = $clog2(NPORT);

  logic              free_c;
  logic [NPORT-1:0]  req_c;
  logic [NPORT-1:0]  gnt_c;
  logic              any_gnt_c;
  logic [SRC_W-1:0]  gnt_idx_c;
  logic [SRC_W-1:0]  ptr_next_c;
  logic [XLEN-1:0]   sel_data_c;
  logic [ITAG_W-1:0] sel_itag_c;
  logic [SRC_W-1:0]  ptr_q;

  // Output register can take a new result when empty or being drained this cycle
  always_comb begin
    free_c = !wb_valid_o || wb_ready_i;
    req_c  = (free_c && !flush_i && !arst_i) ? src_valid_i : '0;
  end

  rr_arbiter #(
    .N  (NPORT),
    .PW (SRC_W)
  ) u_rr (
    .req (req_c),
    .ptr (ptr_q),
    .gnt (gnt_c)
  );

  assign src_ready_o = gnt_c;
  assign any_gnt_c   = |gnt_c;

  // Mux the granted source's payload and encode its index
  always_comb begin
    sel_data_c = '0;
    sel_itag_c = '0;
    gnt_idx_c  = '0;
    for (int unsigned k = 0; k < NPORT; k++) begin
      if (gnt_c[k]) begin
        sel_data_c = src_data_i[k*XLEN +: XLEN];
        sel_itag_c = src_itag_i[k*ITAG_W +: ITAG_W];
        gnt_idx_c  = SRC_W'(k);
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NPORT (not necessarily a power of two)
  always_comb begin
    ptr_next_c = (gnt_idx_c == SRC_W'(NPORT - 1)) ? '0 : gnt_idx_c + SRC_W'(1);
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wb_valid_o <= 1'b0;
      wb_data_o  <= '0;
      wb_itag_o  <= '0;
      wb_src_o   <= '0;
      ptr_q      <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      ptr_q      <= '0;
    end else if (free_c) begin
      wb_valid_o <= any_gnt_c;
      if (any_gnt_c) begin
        wb_data_o <= sel_data_c;
        wb_itag_o <= sel_itag_c;
        wb_src_o  <= gnt_idx_c;
        ptr_q     <= ptr_next_c;
      end
    end
  end

endmodule

// File: tb/tb_wb_arb.sv
// Self-checking bench for wb_arb: directed scenarios plus a randomized scoreboard run.
module tb_wb_arb;
  import prv664_pkg::*;

  localparam int unsigned NPORT  = 4;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned ITAG_W = 8;

  typedef struct packed {
    wb_payload_t pl;
    logic [1:0]  src;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     arst;
  logic                     fl;
  logic [NPORT-1:0]         v;
  logic                     rdy;
  logic [XLEN-1:0]          d [NPORT];
  logic [ITAG_W-1:0]        t [NPORT];
  logic [NPORT*XLEN-1:0]    src_data;
  logic [NPORT*ITAG_W-1:0]  src_itag;
  logic [NPORT-1:0]         src_ready_o;
  logic                     wb_valid_o;
  logic [XLEN-1:0]          wb_data_o;
  logic [ITAG_W-1:0]        wb_itag_o;
  logic [1:0]               wb_src_o;

  assign src_data = {d[3], d[2], d[1], d[0]};
  assign src_itag = {t[3], t[2], t[1], t[0]};

  always #5 clk = ~clk;

  wb_arb #(.NPORT(NPORT), .XLEN(XLEN), .ITAG_W(ITAG_W)) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .flush_i     (fl),
    .src_valid_i (v),
    .src_ready_o (src_ready_o),
    .src_data_i  (src_data),
    .src_itag_i  (src_itag),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (rdy),
    .wb_data_o   (wb_data_o),
    .wb_itag_o   (wb_itag_o),
    .wb_src_o    (wb_src_o)
  );

  int         checks = 0;
  int         failures = 0;
  exp_t       sb [$];
  logic       m_valid;
  logic [1:0] m_ptr;
  int         wait_cnt [NPORT];
  logic [3:0] last_gnt;

  function automatic logic [3:0] rr_model(input logic [3:0] req, input logic [1:0] p);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] idx;
      idx = p + 2'(i);
      if (req[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_ptr    = 2'd0;
    last_gnt = 4'b0;
    sb.delete();
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
  endtask

  // One clock cycle: drive, check grant vs model, push/pop scoreboard, check outputs
  task automatic step(input logic [3:0] nv, input logic nrdy, input logic nfl);
    logic       exp_free;
    logic       pfree;
    logic [3:0] exp_gnt;
    logic [3:0] obs;
    logic [XLEN-1:0]   hd;
    logic [ITAG_W-1:0] ht;
    logic [1:0] hs;
    exp_t       e;
    v = nv; rdy = nrdy; fl = nfl;
    @(negedge clk);
    exp_free = !m_valid || nrdy;
    exp_gnt  = (exp_free && !nfl) ? rr_model(nv, m_ptr) : 4'b0;
    checks++;
    if (src_ready_o !== exp_gnt) begin
      failures++;
      $display("FAIL grant: src_ready_o=%b expected=%b (valid=%b ptr=%0d)", src_ready_o, exp_gnt, nv, m_ptr);
    end
    obs = src_ready_o & nv;
    if (!nfl) begin
      for (int k = 0; k < 4; k++) begin
        if (obs[k]) begin
          e.pl.data = d[k]; e.pl.itag = t[k]; e.src = 2'(k);
          sb.push_back(e);
        end
      end
    end
    if (nfl) begin
      for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    end else if (|obs) begin
      for (int k = 0; k < 4; k++) begin
        if (!nv[k]) wait_cnt[k] = 0;
        else if (obs[k]) begin
          checks++;
          if (wait_cnt[k] >= int'(NPORT)) begin
            failures++;
            $display("FAIL fairness: source %0d waited %0d grants, limit %0d", k, wait_cnt[k], NPORT - 1);
          end
          wait_cnt[k] = 0;
        end else wait_cnt[k]++;
      end
    end
    pfree = !wb_valid_o || nrdy;
    hd = wb_data_o; ht = wb_itag_o; hs = wb_src_o;
    last_gnt = obs;
    @(posedge clk); #1;
    if (nfl) begin
      m_valid = 1'b0; m_ptr = 2'd0;
    end else if (exp_free) begin
      m_valid = |exp_gnt;
      if (|exp_gnt) m_ptr = onehot_idx(exp_gnt) + 2'd1;
    end
    checks++;
    if (wb_valid_o !== m_valid) begin
      failures++;
      $display("FAIL wb_valid: got %b expected %b", wb_valid_o, m_valid);
    end
    if (!nfl && pfree && wb_valid_o === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard: output itag=%h src=%0d with no accepted result pending", wb_itag_o, wb_src_o);
      end else begin
        e = sb.pop_front();
        if ({wb_data_o, wb_itag_o, wb_src_o} !== {e.pl.data, e.pl.itag, e.src}) begin
          failures++;
          $display("FAIL scoreboard: got data=%h itag=%h src=%0d expected data=%h itag=%h src=%0d",
                   wb_data_o, wb_itag_o, wb_src_o, e.pl.data, e.pl.itag, e.src);
        end
      end
    end else if (!nfl && !pfree) begin
      checks++;
      if ({wb_data_o, wb_itag_o, wb_src_o} !== {hd, ht, hs}) begin
        failures++;
        $display("FAIL hold: got data=%h itag=%h src=%0d expected data=%h itag=%h src=%0d",
                 wb_data_o, wb_itag_o, wb_src_o, hd, ht, hs);
      end
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1; v = 4'hF; rdy = 1'b1; fl = 1'b0;
    for (int k = 0; k < 4; k++) begin d[k] = 64'hDEAD_0000 + 64'(k); t[k] = 8'hE0 + 8'(k); end
    #2;
    checks++;
    if (src_ready_o !== 4'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0000", src_ready_o); end
    @(posedge clk); #1;
    checks++;
    if ({wb_valid_o, wb_data_o, wb_itag_o, wb_src_o} !== '0) begin
      failures++;
      $display("FAIL reset_out: valid=%b data=%h itag=%h src=%0d expected all zero", wb_valid_o, wb_data_o, wb_itag_o, wb_src_o);
    end
    checks++;
    if (src_ready_o !== 4'b0) begin failures++; $display("FAIL reset_ready_hold: got %b expected 0000", src_ready_o); end
    model_reset();
    arst = 1'b0;
    v = 4'b0;
  endtask

  task automatic test_single();
    do_reset();
    d[2] = 64'h1234; t[2] = 8'h05; v = 4'b0100; rdy = 1'b1; fl = 1'b0;
    #1;
    checks++;
    if (src_ready_o !== 4'b0100) begin failures++; $display("FAIL single_ready: got %b expected 0100", src_ready_o); end
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if ({wb_valid_o, wb_data_o, wb_itag_o, wb_src_o} !== {1'b1, 64'h1234, 8'h05, 2'd2}) begin
      failures++;
      $display("FAIL single_out: valid=%b data=%h itag=%h src=%0d expected 1/1234/05/2", wb_valid_o, wb_data_o, wb_itag_o, wb_src_o);
    end
    step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL single_drain: wb_valid_o=%b expected 0", wb_valid_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 4; k++) begin d[k] = 64'hA000 + 64'(k); t[k] = 8'h10 + 8'(k); end
    for (int c = 0; c < 5; c++) begin
      step(4'hF, 1'b1, 1'b0);
      checks++;
      if ({wb_valid_o, wb_src_o, wb_itag_o} !== {1'b1, 2'(c % 4), 8'h10 + 8'(c % 4)}) begin
        failures++;
        $display("FAIL rr_order cycle %0d: valid=%b src=%0d itag=%h expected 1/%0d/%h", c, wb_valid_o, wb_src_o, wb_itag_o, c % 4, 8'h10 + 8'(c % 4));
      end
    end
    step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    step(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      v = 4'b0010; rdy = 1'b0;
      #1;
      checks++;
      if (src_ready_o !== 4'b0) begin failures++; $display("FAIL bp_ready cycle %0d: got %b expected 0000", c, src_ready_o); end
      step(4'b0010, 1'b0, 1'b0);
      checks++;
      if ({wb_valid_o, wb_src_o} !== {1'b1, 2'd0}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: valid=%b src=%0d expected 1/0", c, wb_valid_o, wb_src_o);
      end
    end
    rdy = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 4'b0010) begin failures++; $display("FAIL bp_release: got %b expected 0010", src_ready_o); end
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if ({wb_valid_o, wb_src_o} !== {1'b1, 2'd1}) begin
      failures++;
      $display("FAIL bp_out: valid=%b src=%0d expected 1/1", wb_valid_o, wb_src_o);
    end
    step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    d[1] = 64'hF1; t[1] = 8'h22;
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if ({wb_valid_o, wb_itag_o} !== {1'b1, 8'h22}) begin
      failures++;
      $display("FAIL flush_setup: valid=%b itag=%h expected 1/22", wb_valid_o, wb_itag_o);
    end
    v = 4'b1000; rdy = 1'b0; fl = 1'b1;
    #1;
    checks++;
    if (src_ready_o !== 4'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0000", src_ready_o); end
    step(4'b1000, 1'b0, 1'b1);
    checks++;
    if (wb_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid: got %b expected 0", wb_valid_o); end
    step(4'hF, 1'b1, 1'b0);
    checks++;
    if ({wb_valid_o, wb_src_o} !== {1'b1, 2'd0}) begin
      failures++;
      $display("FAIL flush_ptr: valid=%b src=%0d expected 1/0", wb_valid_o, wb_src_o);
    end
    step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 3; c++) step(4'b1100, 1'b1, 1'b0);
    #2;
    arst = 1'b1;
    #1;
    checks++;
    if ({wb_valid_o, src_ready_o} !== 5'b0) begin
      failures++;
      $display("FAIL arst_immediate: valid=%b ready=%b expected 0/0000", wb_valid_o, src_ready_o);
    end
    @(posedge clk); #1;
    model_reset();
    arst = 1'b0;
    #1;
    checks++;
    if (src_ready_o !== 4'b0100) begin failures++; $display("FAIL arst_first_grant: got %b expected 0100", src_ready_o); end
    step(4'b1100, 1'b1, 1'b0);
    checks++;
    if ({wb_valid_o, wb_src_o} !== {1'b1, 2'd2}) begin
      failures++;
      $display("FAIL arst_out: valid=%b src=%0d expected 1/2", wb_valid_o, wb_src_o);
    end
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] nv;
    logic       nrdy;
    logic       nfl;
    for (int n = 0; n < 10000; n++) begin
      nv = v;
      for (int k = 0; k < 4; k++) begin
        if (!v[k] || last_gnt[k]) begin
          nv[k] = ($urandom_range(1, 0) == 1);
          d[k]  = {$urandom, $urandom};
          t[k]  = 8'($urandom);
        end
      end
      nrdy = ($urandom_range(3, 0) != 0);
      nfl  = ($urandom_range(63, 0) == 0);
      step(nv, nrdy, nfl);
    end
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL random_drain: %0d accepted results never written back, expected 0", sb.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter NPORT, default 4, number of execution-unit writeback sources (2..8).
REQ-002 SHALL have parameter XLEN, default 64, result data width.
REQ-003 SHALL have parameter ITAG_W, default 8, instruction tag width.
REQ-004 clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 arst_i  input  1  reset, asynchronous, active-high.
REQ-006 flush_i  input  1  pipeline flush, synchronous, active-high.
REQ-007 src_valid_i  input  NPORT  per-source result valid.
REQ-008 src_ready_o  output  NPORT  per-source accept; a transfer occurs when valid and ready are both high.
REQ-009 src_data_i  input  NPORT*XLEN  per-source result data; source k occupies bits [k*XLEN +: XLEN].
REQ-010 src_itag_i  input  NPORT*ITAG_W  per-source instruction tag.
REQ-011 wb_valid_o  output  1  writeback valid toward ROB/regfile.
REQ-012 wb_ready_i  input  1  ROB/regfile accept.
REQ-013 wb_data_o  output  XLEN  registered result data.
REQ-014 wb_itag_o  output  ITAG_W  registered tag.
REQ-015 wb_src_o  output  $clog2(NPORT)  index of the source that produced the current output.

Function
REQ-016 Sources SHALL be treated as holding valid, data and itag stable until accepted; the block SHALL NOT depend on any source dropping valid.
REQ-017 Output register "free" SHALL be: !wb_valid_o | wb_ready_i.
REQ-018 When free and at least one src_valid_i is high, exactly one source SHALL be granted; src_ready_o is one-hot on the granted source and zero on all others.
REQ-019 When not free, or when flush_i=1, src_ready_o SHALL be all zero.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer ptr and wraps from NPORT-1 to 0; the first valid source found is granted.
REQ-021 On each grant to source g, ptr SHALL become (g+1) mod NPORT in the next cycle; ptr is unchanged in cycles with no grant.
REQ-022 A granted source's data, itag and index SHALL appear on wb_*_o with wb_valid_o=1 in the cycle after the grant (latency 1).
REQ-023 When free with no grant, wb_valid_o SHALL drop to 0 next cycle; when not free, all wb_*_o outputs SHALL hold.
REQ-024 Simultaneous drain and grant (wb_valid_o=1, wb_ready_i=1, a source valid) SHALL load the new result back-to-back, sustaining 1 result/cycle.
REQ-025 Fairness: a continuously valid source SHALL be granted within NPORT grants.
REQ-026 flush_i=1 SHALL clear wb_valid_o next cycle and reset ptr to 0; a result presented in the flush cycle is discarded and not counted as written back.
REQ-027 wb_data_o, wb_itag_o and wb_src_o SHALL be don't-care while wb_valid_o=0.

Reset
REQ-028 On arst_i: wb_valid_o=0, ptr=0, wb_data_o=0, wb_itag_o=0, wb_src_o=0; src_ready_o=0 while arst_i is high.
REQ-029 Reset assertion mid-transfer SHALL discard the held result; the first grant after release SHALL go to the lowest-index valid source.

Structure
REQ-030 The writeback payload struct {data, itag} and the default values of NPORT, XLEN and ITAG_W SHALL be defined in the shared prv664 package.
REQ-031 Round-robin grant logic SHALL be one sub-module, rr_arbiter (inputs req, ptr; output one-hot gnt), reusable by the issue stage.
REQ-032 The output register and ptr SHALL be implemented in wb_arb.

Verification
REQ-033 Single source: src_valid_i=4'b0100, data=64'h1234, itag=8'h05, wb_ready_i=1 -> src_ready_o=4'b0100 in the same cycle; next cycle wb_valid_o=1, wb_data_o=64'h1234, wb_itag_o=8'h05, wb_src_o=2.
REQ-034 All four sources valid continuously, wb_ready_i=1, after reset -> grant order 0,1,2,3,0 on consecutive cycles, one result per cycle.
REQ-035 Backpressure: wb_valid_o=1, wb_ready_i=0 for 3 cycles with src 1 valid -> src_ready_o=0 and outputs stable for 3 cycles; when wb_ready_i=1, src 1 is granted in that cycle.
REQ-036 Flush: wb_valid_o=1 holding itag 8'h22, flush_i=1 with src 3 valid -> src_ready_o=0; next cycle wb_valid_o=0 and ptr=0.
REQ-037 Async reset asserted mid-stream with sources 2 and 3 valid -> wb_valid_o=0 immediately; after release, first grant goes to source 2.
REQ-038 Random stimulus, 10k cycles, with a scoreboard -> every accepted (itag, data) appears on wb_*_o exactly once and in grant order, and no source waits more than NPORT grants.
